// File: rtl/password_ctrl.sv
// Digit-entry password controller: unlock, two-step password change and timed lockout.
// Entry buffer shifts digits in MS-first; every output is driven straight from a flop.
module password_ctrl #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DIGIT_W  = 4,
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned LOCK_CYC = 1000,
  parameter logic [N_DIGITS*DIGIT_W-1:0] INIT_PW = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          key_valid,
  input  logic [DIGIT_W-1:0]            key_digit,
  input  logic                          key_clr,
  input  logic                          submit,
  input  logic                          set_req,
  output logic                          unlocked,
  output logic                          set_mode,
  output logic                          confirm_phase,
  output logic                          locked_out,
  output logic                          err_pulse,
  output logic                          ok_pulse,
  output logic [3:0]                    digit_cnt,
  output logic [3:0]                    fail_cnt,
  output logic [N_DIGITS*DIGIT_W-1:0]   stored_pw
);

  localparam int unsigned PW_W   = N_DIGITS * DIGIT_W;
  localparam int unsigned TimerW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StOpen       = 3'd1;
  localparam logic [2:0] StSetNew     = 3'd2;
  localparam logic [2:0] StSetConfirm = 3'd3;
  localparam logic [2:0] StLockout    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [PW_W-1:0]   entry_q, entry_d;
  logic [PW_W-1:0]   cand_q, cand_d;
  logic [PW_W-1:0]   pw_q, pw_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        fail_q, fail_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              err_q, err_d;
  logic              ok_q, ok_d;
  logic              unlocked_q, set_mode_q, confirm_q, locked_q;
  logic              full;

  assign full = (cnt_q == 4'(N_DIGITS));

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cand_d  = cand_q;
    pw_d    = pw_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    ok_d    = 1'b0;

    if (state_q == StLockout) begin
      // Timer was loaded with LOCK_CYC-1, so exiting on zero gives LOCK_CYC cycles of dwell.
      if (timer_q == '0) begin
        state_d = StIdle;
        fail_d  = '0;
      end else begin
        timer_d = timer_q - TimerW'(1);
      end
    end else if (set_req) begin
      case (state_q)
        StOpen: begin
          state_d = StSetNew;
          entry_d = '0;
          cnt_d   = '0;
        end
        StSetNew, StSetConfirm: begin
          state_d = StOpen;
          cand_d  = '0;
          entry_d = '0;
          cnt_d   = '0;
        end
        default: ;
      endcase
    end else if (submit) begin
      entry_d = '0;
      cnt_d   = '0;
      case (state_q)
        StIdle: begin
          if (full && (entry_q == pw_q)) begin
            state_d = StOpen;
            ok_d    = 1'b1;
            fail_d  = '0;
          end else begin
            err_d  = 1'b1;
            fail_d = fail_q + 4'd1;
            if (fail_d == 4'(MAX_FAIL)) begin
              state_d = StLockout;
              timer_d = TimerW'(LOCK_CYC - 1);
            end
          end
        end
        StOpen: begin
          state_d = StIdle;
          ok_d    = 1'b1;
        end
        StSetNew: begin
          if (full) begin
            cand_d  = entry_q;
            state_d = StSetConfirm;
            ok_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        StSetConfirm: begin
          cand_d = '0;
          if (full && (entry_q == cand_q)) begin
            pw_d    = cand_q;
            state_d = StIdle;
            ok_d    = 1'b1;
          end else begin
            state_d = StSetNew;
            err_d   = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (key_clr) begin
      entry_d = '0;
      cnt_d   = '0;
    end else if (key_valid && !full) begin
      entry_d = (entry_q << DIGIT_W) | PW_W'(key_digit);
      cnt_d   = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      entry_q    <= '0;
      cand_q     <= '0;
      pw_q       <= INIT_PW;
      cnt_q      <= '0;
      fail_q     <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      ok_q       <= 1'b0;
      unlocked_q <= 1'b0;
      set_mode_q <= 1'b0;
      confirm_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      cand_q     <= cand_d;
      pw_q       <= pw_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      ok_q       <= ok_d;
      unlocked_q <= (state_d == StOpen);
      set_mode_q <= (state_d == StSetNew) || (state_d == StSetConfirm);
      confirm_q  <= (state_d == StSetConfirm);
      locked_q   <= (state_d == StLockout);
    end
  end

  assign unlocked      = unlocked_q;
  assign set_mode      = set_mode_q;
  assign confirm_phase = confirm_q;
  assign locked_out    = locked_q;
  assign err_pulse     = err_q;
  assign ok_pulse      = ok_q;
  assign digit_cnt     = cnt_q;
  assign fail_cnt      = fail_q;
  assign stored_pw     = pw_q;

endmodule

// File: tb/tb_password_ctrl.sv
// Scoreboard bench for password_ctrl: submits queue their expected response, a monitor
// pops on every ok/err pulse; level outputs are checked directly from the stimulus thread.
module tb_password_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = '0;
  logic        key_clr = 1'b0;
  logic        submit = 1'b0;
  logic        set_req = 1'b0;
  logic        unlocked, set_mode, confirm_phase, locked_out, err_pulse, ok_pulse;
  logic [3:0]  digit_cnt, fail_cnt;
  logic [15:0] stored_pw;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        ok;
    logic        err;
    logic        unl;
    logic        sm;
    logic        cf;
    logic        lo;
    logic [3:0]  fail;
    logic [15:0] pw;
  } exp_t;

  exp_t exp_q[$];

  password_ctrl #(
    .N_DIGITS(4),
    .DIGIT_W (4),
    .MAX_FAIL(3),
    .LOCK_CYC(8),
    .INIT_PW (16'h1234)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .key_clr      (key_clr),
    .submit       (submit),
    .set_req      (set_req),
    .unlocked     (unlocked),
    .set_mode     (set_mode),
    .confirm_phase(confirm_phase),
    .locked_out   (locked_out),
    .err_pulse    (err_pulse),
    .ok_pulse     (ok_pulse),
    .digit_cnt    (digit_cnt),
    .fail_cnt     (fail_cnt),
    .stored_pw    (stored_pw)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (ok_pulse || err_pulse)) begin
      exp_t act;
      exp_t e;
      act = '{ok: ok_pulse, err: err_pulse, unl: unlocked, sm: set_mode, cf: confirm_phase,
              lo: locked_out, fail: fail_cnt, pw: stored_pw};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got ok=%b err=%b, required no pulse", ok_pulse,
                 err_pulse);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL pulse_resp: got ok=%b err=%b unl=%b sm=%b cf=%b lo=%b fail=%0d pw=%h, required ok=%b err=%b unl=%b sm=%b cf=%b lo=%b fail=%0d pw=%h",
                   act.ok, act.err, act.unl, act.sm, act.cf, act.lo, act.fail, act.pw,
                   e.ok, e.err, e.unl, e.sm, e.cf, e.lo, e.fail, e.pw);
        end
      end
    end
  end

  function automatic exp_t mk(logic ok, logic err, logic unl, logic sm, logic cf, logic lo,
                              logic [3:0] fail, logic [15:0] pw);
    return '{ok: ok, err: err, unl: unl, sm: sm, cf: cf, lo: lo, fail: fail, pw: pw};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter(input logic [15:0] pw, input int n);
    for (int i = 0; i < n; i++) key(pw[15-4*i -: 4]);
  endtask

  task automatic sub(input exp_t e);
    exp_q.push_back(e);
    submit = 1'b1;
    tick();
    submit = 1'b0;
  endtask

  task automatic set_pulse();
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
  endtask

  initial begin
    int dwell;

    // Reset state
    #22;
    check("rst_unlocked", 32'(unlocked), 32'd0);
    check("rst_set_mode", 32'(set_mode), 32'd0);
    check("rst_locked", 32'(locked_out), 32'd0);
    check("rst_pulses", 32'({err_pulse, ok_pulse}), 32'd0);
    check("rst_digit_cnt", 32'(digit_cnt), 32'd0);
    check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    check("rst_stored_pw", 32'(stored_pw), 32'h1234);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Saturation: fifth key ignored, so 1234 still unlocks
    enter(16'h1234, 4);
    check("digit_cnt_full", 32'(digit_cnt), 32'd4);
    key(4'h5);
    check("digit_cnt_sat", 32'(digit_cnt), 32'd4);
    sub(mk(1, 0, 1, 0, 0, 0, 4'd0, 16'h1234));
    check("unlocked_after_ok", 32'(unlocked), 32'd1);
    sub(mk(1, 0, 0, 0, 0, 0, 4'd0, 16'h1234));

    // Short entry rejected; key_clr beats key_valid
    enter(16'h1234, 3);
    check("digit_cnt_three", 32'(digit_cnt), 32'd3);
    sub(mk(0, 1, 0, 0, 0, 0, 4'd1, 16'h1234));
    check("digit_cnt_after_submit", 32'(digit_cnt), 32'd0);
    enter(16'h1200, 2);
    key_clr = 1'b1;
    key(4'h9);
    key_clr = 1'b0;
    check("clr_beats_key", 32'(digit_cnt), 32'd0);
    enter(16'h1234, 4);
    sub(mk(1, 0, 1, 0, 0, 0, 4'd0, 16'h1234));
    sub(mk(1, 0, 0, 0, 0, 0, 4'd0, 16'h1234));

    // Lockout after three bad tries
    enter(16'h1235, 4);
    sub(mk(0, 1, 0, 0, 0, 0, 4'd1, 16'h1234));
    enter(16'h1235, 4);
    sub(mk(0, 1, 0, 0, 0, 0, 4'd2, 16'h1234));
    enter(16'h1235, 4);
    sub(mk(0, 1, 0, 0, 0, 1, 4'd3, 16'h1234));

    // Dwell: correct code and submit during lockout must produce nothing
    dwell = 0;
    for (int i = 0; i < 20 && locked_out; i++) begin
      dwell++;
      if (i < 4) begin
        key_valid = 1'b1;
        key_digit = 4'(i + 1);
      end else if (i == 4) begin
        submit = 1'b1;
      end
      tick();
      key_valid = 1'b0;
      submit = 1'b0;
    end
    check("lockout_dwell", 32'(dwell), 32'd8);
    check("fail_cnt_after_lockout", 32'(fail_cnt), 32'd0);
    check("unlocked_after_lockout", 32'(unlocked), 32'd0);
    check("digit_cnt_after_lockout", 32'(digit_cnt), 32'd0);

    // Set flow with errors and an abort
    enter(16'h1234, 4);
    sub(mk(1, 0, 1, 0, 0, 0, 4'd0, 16'h1234));
    set_pulse();
    check("set_mode_entered", 32'({set_mode, confirm_phase, unlocked}), 32'b100);
    enter(16'h9800, 2);
    sub(mk(0, 1, 0, 1, 0, 0, 4'd0, 16'h1234));
    enter(16'h9876, 4);
    sub(mk(1, 0, 0, 1, 1, 0, 4'd0, 16'h1234));
    enter(16'h9875, 4);
    sub(mk(0, 1, 0, 1, 0, 0, 4'd0, 16'h1234));
    enter(16'h9876, 4);
    sub(mk(1, 0, 0, 1, 1, 0, 4'd0, 16'h1234));
    set_pulse();
    check("abort_to_open", 32'({set_mode, confirm_phase, unlocked}), 32'b001);
    check("abort_pw_kept", 32'(stored_pw), 32'h1234);
    set_pulse();
    enter(16'h9876, 4);
    sub(mk(1, 0, 0, 1, 1, 0, 4'd0, 16'h1234));
    enter(16'h9876, 4);
    sub(mk(1, 0, 0, 0, 0, 0, 4'd0, 16'h9876));
    enter(16'h1234, 4);
    sub(mk(0, 1, 0, 0, 0, 0, 4'd1, 16'h9876));
    enter(16'h9876, 4);
    sub(mk(1, 0, 1, 0, 0, 0, 4'd0, 16'h9876));

    // Reset in SET_CONFIRM restores the initial password
    set_pulse();
    enter(16'h5555, 4);
    sub(mk(1, 0, 0, 1, 1, 0, 4'd0, 16'h9876));
    enter(16'h5500, 2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_set_pw", 32'(stored_pw), 32'h1234);
    check("rst_mid_set_flags", 32'({set_mode, confirm_phase, unlocked, digit_cnt}), 32'd0);
    tick();
    rst_n = 1'b1;
    enter(16'h5555, 4);
    sub(mk(0, 1, 0, 0, 0, 0, 4'd1, 16'h1234));
    enter(16'h1234, 4);
    sub(mk(1, 0, 1, 0, 0, 0, 4'd0, 16'h1234));

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/password_ctrl.md
PASSWORD_CTRL -- requirements
Module: password_ctrl

Interface
REQ-001 The block SHALL take parameter N_DIGITS, default 4, which sets the password length in digits (range 1..8).
REQ-002 The block SHALL take parameter DIGIT_W, default 4, which sets the bits per digit.
REQ-003 The block SHALL take parameter MAX_FAIL, default 3, which sets the number of consecutive failed unlocks that triggers lockout (range 1..15).
REQ-004 The block SHALL take parameter LOCK_CYC, default 1000, which sets the lockout duration in clk cycles (at least 1).
REQ-005 The block SHALL take parameter INIT_PW, default 0, a PW_W-bit value loaded into the stored password at reset, where PW_W = N_DIGITS*DIGIT_W.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 key_valid  in  1  one-cycle strobe; key_digit is accepted on this cycle.
REQ-009 key_digit  in  DIGIT_W  digit value.
REQ-010 key_clr  in  1  discards the partial entry.
REQ-011 submit  in  1  one-cycle strobe that evaluates the current entry.
REQ-012 set_req  in  1  one-cycle strobe that enters or aborts password-set mode.
REQ-013 unlocked  out  1  high while in state OPEN.
REQ-014 set_mode  out  1  high while in SET_NEW or SET_CONFIRM.
REQ-015 confirm_phase  out  1  high while in SET_CONFIRM.
REQ-016 locked_out  out  1  high while in state LOCKOUT.
REQ-017 err_pulse  out  1  one-cycle pulse on every rejected submit.
REQ-018 ok_pulse  out  1  one-cycle pulse on every accepted submit.
REQ-019 digit_cnt  out  4  number of digits currently held in the entry.
REQ-020 fail_cnt  out  4  count of consecutive failed unlocks.
REQ-021 stored_pw  out  PW_W  current stored password.

Function
REQ-022 All outputs SHALL be registered; the response to a strobe SHALL be visible on the cycle after the strobe is sampled.
REQ-023 Entry buffer: on key_valid with digit_cnt < N_DIGITS, the buffer SHALL shift left by DIGIT_W, load key_digit into the LS digit, and increment digit_cnt; the first digit entered ends up MS.
REQ-024 On key_valid with digit_cnt = N_DIGITS, the digit SHALL be ignored (no change, no error).
REQ-025 Per-cycle priority SHALL be set_req > submit > key_clr > key_valid; a strobe that loses SHALL be discarded.
REQ-026 Every submit, key_clr and state change SHALL zero the buffer and digit_cnt.
REQ-027 An entry SHALL be "full" when digit_cnt = N_DIGITS; a submit with a non-full entry SHALL be a reject.
REQ-028 FSM states SHALL be IDLE (locked), OPEN, SET_NEW, SET_CONFIRM and LOCKOUT.
REQ-029 IDLE, submit with a full entry equal to stored_pw: go to OPEN, ok_pulse, fail_cnt <= 0.
REQ-030 IDLE, any other submit: err_pulse, fail_cnt+1; if the new fail_cnt = MAX_FAIL, go to LOCKOUT and load the lock timer with LOCK_CYC-1.
REQ-031 IDLE, set_req: SHALL be ignored.
REQ-032 OPEN, set_req: go to SET_NEW.
REQ-033 OPEN, submit (any entry): go to IDLE (relock), ok_pulse.
REQ-034 SET_NEW, submit with a full entry: latch the candidate, go to SET_CONFIRM, ok_pulse.
REQ-035 SET_NEW, submit with a non-full entry: err_pulse, stay in SET_NEW.
REQ-036 SET_CONFIRM, submit with a full entry equal to the candidate: stored_pw <= candidate, go to IDLE, ok_pulse.
REQ-037 SET_CONFIRM, any other submit: err_pulse, candidate discarded, go to SET_NEW, stored_pw unchanged.
REQ-038 SET_NEW or SET_CONFIRM, set_req: abort to OPEN, stored_pw unchanged, no pulse.
REQ-039 Set-mode errors SHALL NOT change fail_cnt.
REQ-040 LOCKOUT: all inputs SHALL be ignored.
REQ-041 LOCKOUT: the timer SHALL decrement each cycle; on the cycle it reads 0, go to IDLE with fail_cnt <= 0; total LOCKOUT dwell SHALL be exactly LOCK_CYC cycles.
REQ-042 err_pulse and ok_pulse SHALL never be high in the same cycle.
REQ-043 stored_pw SHALL change only per REQ-036.

Reset
REQ-044 While rst_n = 0 the block SHALL hold: state IDLE, stored_pw = INIT_PW, candidate 0, buffer 0, digit_cnt 0, fail_cnt 0, timer 0.
REQ-045 While rst_n = 0 the block SHALL hold: unlocked, set_mode, confirm_phase, locked_out, err_pulse and ok_pulse all 0.
REQ-046 Reset asserted mid-entry, mid-set or mid-lockout SHALL discard all progress; a partial set SHALL never reach stored_pw.
REQ-047 Deassertion SHALL be synchronised to clk; the first strobe SHALL be honoured on the first rising edge after deassertion.

Verification
(All cases use N_DIGITS=4, DIGIT_W=4, MAX_FAIL=3, LOCK_CYC=8, INIT_PW=16'h1234.)
REQ-048 Unlock: keys 1,2,3,4 then submit -> next cycle unlocked=1, ok_pulse=1, fail_cnt=0; a further submit -> unlocked=0.
REQ-049 Lockout: three submits of 1,2,3,5 -> err_pulse each time, fail_cnt 1,2,3, locked_out=1.
REQ-050 Lockout dwell: during lockout, correct keys 1,2,3,4 plus submit are ignored; locked_out stays high exactly 8 cycles, then IDLE with fail_cnt=0.
REQ-051 Set flow: unlock; set_req; keys 9,8,7,6 submit -> confirm_phase=1; keys 9,8,7,6 submit -> stored_pw=16'h9876, state IDLE; a later unlock with 9,8,7,6 succeeds and with 1,2,3,4 fails.
REQ-052 Set errors: confirm with 9,8,7,5 -> err_pulse, back to SET_NEW, stored_pw=16'h1234; set_req in SET_CONFIRM -> OPEN, stored_pw unchanged.
REQ-053 Boundaries: 5 keys entered -> digit_cnt saturates at 4 and the 5th key is ignored; submit after 3 keys -> reject; key_valid with key_clr in the same cycle -> digit_cnt=0; rst_n pulsed during SET_CONFIRM -> stored_pw=16'h1234.
